// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction-fetch front end; owns the PC, issues one imem read at
//            a time and fills the IF/ID register for decode.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HLT_OPC  = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus2,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_BUF   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_buf;
    logic        r_drop;
    logic        r_ifid_valid;
    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc;
    logic [15:0] r_ifid_pc_plus2;
    logic        r_halted;

    logic [15:0] w_pc_plus2;
    logic        w_load_mem;
    logic        w_load_buf;
    logic        w_load;
    logic [15:0] w_word;
    logic        w_is_hlt;

    assign w_pc_plus2 = r_pc + 16'd2;
    assign w_load_mem = (r_state == S_WAIT) && imem_rvalid && !r_drop
                        && (!stall || !r_ifid_valid);
    assign w_load_buf = (r_state == S_BUF) && !stall;
    assign w_load     = w_load_mem || w_load_buf;
    assign w_word     = w_load_buf ? r_buf : imem_rdata;
    assign w_is_hlt   = (w_word[15:12] == HLT_OPC);

    // Request is gated by rst so nothing escapes while reset is held.
    assign imem_req      = (r_state == S_FETCH) && !rst;
    assign imem_addr     = r_pc;
    assign ifid_valid    = r_ifid_valid;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_pc_plus2 = r_ifid_pc_plus2;
    assign halted        = r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_FETCH;
            r_pc            <= RESET_PC;
            r_buf           <= 16'h0000;
            r_drop          <= 1'b0;
            r_ifid_valid    <= 1'b0;
            r_ifid_instr    <= 16'h0000;
            r_ifid_pc       <= 16'h0000;
            r_ifid_pc_plus2 <= 16'h0000;
            r_halted        <= 1'b0;
        end else if (redirect) begin
            r_ifid_valid <= 1'b0;
            r_buf        <= 16'h0000;
            r_pc         <= redirect_pc & 16'hFFFE;
            r_halted     <= 1'b0;
            case (r_state)
                // A request is (or was just) in flight: its response must be dropped.
                S_FETCH: begin
                    r_state <= S_WAIT;
                    r_drop  <= 1'b1;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_FETCH;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                    r_drop  <= 1'b0;
                end
            endcase
        end else begin
            if (w_load) begin
                r_ifid_valid    <= 1'b1;
                r_ifid_instr    <= w_word;
                r_ifid_pc       <= r_pc;
                r_ifid_pc_plus2 <= w_pc_plus2;
                r_pc            <= w_pc_plus2;
                if (w_is_hlt) begin
                    r_halted <= 1'b1;
                end
            end else if (!stall) begin
                r_ifid_valid <= 1'b0;
            end

            case (r_state)
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_FETCH;
                        end else if (w_load_mem) begin
                            r_state <= w_is_hlt ? S_HALT : S_FETCH;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= S_BUF;
                        end
                    end
                end
                S_BUF: begin
                    if (!stall) begin
                        r_state <= w_is_hlt ? S_HALT : S_FETCH;
                    end
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage with a
//            variable-latency instruction memory responder.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus2;
    logic        halted;

    int n_total = 0;
    int n_bad   = 0;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .HLT_OPC  (4'hF)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: each request seen mid-cycle returns lat cycles later.
    typedef struct {
        int          due;
        logic [15:0] addr;
    } req_t;

    logic [15:0] mem [0:255];
    req_t        pend [$];
    int          cyc = 0;
    int          lat = 1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        imem_rvalid = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem[pend[0].addr[8:1]];
            pend.delete(0);
        end
        if (imem_req) begin
            pend.push_back('{cyc + lat, imem_addr});
        end
    end

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench 2 time units into cycle 0 after reset release.
    task automatic do_reset();
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        step(1);
        check_val("rst_req",   {15'd0, imem_req},   16'd0);
        check_val("rst_valid", {15'd0, ifid_valid}, 16'd0);
        check_val("rst_instr", ifid_instr,          16'h0000);
        check_val("rst_halt",  {15'd0, halted},     16'd0);
        step(5);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nreq;
        int nvalid;
        int overlap;
        int hold_bad;
        logic prev;

        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]    = 16'h1123;
        mem[1]    = 16'h2456;
        mem[2]    = 16'h3789;
        mem[3]    = 16'hF000;
        mem[8]    = 16'h6001;
        mem[8'h20] = 16'h5A5A;

        // Latency 1 basic flow
        lat = 1;
        do_reset();
        check_val("t1_req0",  {15'd0, imem_req}, 16'd1);
        check_val("t1_addr0", imem_addr,         16'h0000);
        step(1);
        check_val("t1_req1",  {15'd0, imem_req}, 16'd0);
        step(1);
        check_val("t1_v2",    {15'd0, ifid_valid}, 16'd1);
        check_val("t1_i2",    ifid_instr,    16'h1123);
        check_val("t1_pc2",   ifid_pc,       16'h0000);
        check_val("t1_pp2",   ifid_pc_plus2, 16'h0002);
        check_val("t1_addr2", imem_addr,     16'h0002);
        check_val("t1_rq2",   {15'd0, imem_req}, 16'd1);
        step(1);
        check_val("t1_v3",    {15'd0, ifid_valid}, 16'd0);
        step(1);
        check_val("t1_v4",    {15'd0, ifid_valid}, 16'd1);
        check_val("t1_i4",    ifid_instr,    16'h2456);
        check_val("t1_pc4",   ifid_pc,       16'h0002);
        check_val("t1_pp4",   ifid_pc_plus2, 16'h0004);

        // Latency 3 throughput
        lat = 3;
        do_reset();
        nreq = 0; nvalid = 0; overlap = 0; prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (imem_req) nreq++;
            if (ifid_valid) nvalid++;
            if (ifid_valid && prev) overlap++;
            prev = ifid_valid;
            step(1);
        end
        check_val("t2_nreq",    16'(nreq),    16'd4);
        check_val("t2_nvalid",  16'(nvalid),  16'd3);
        check_val("t2_overlap", 16'(overlap), 16'd0);

        // Stall while second word returns
        lat = 1;
        do_reset();
        step(2);
        check_val("t3_v2", ifid_instr, 16'h1123);
        stall = 1'b1;
        step(1);
        hold_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req || !ifid_valid || ifid_instr != 16'h1123 || ifid_pc != 16'h0000)
                hold_bad++;
            if (i < 3) step(1);
        end
        check_val("t3_hold", 16'(hold_bad), 16'd0);
        stall = 1'b0;
        step(1);
        check_val("t3_v",    {15'd0, ifid_valid}, 16'd1);
        check_val("t3_i",    ifid_instr,    16'h2456);
        check_val("t3_pc",   ifid_pc,       16'h0002);
        check_val("t3_pp",   ifid_pc_plus2, 16'h0004);
        check_val("t3_req",  {15'd0, imem_req}, 16'd1);
        check_val("t3_addr", imem_addr,     16'h0004);

        // Redirect while waiting on memory
        lat = 3;
        do_reset();
        step(1);
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        step(1);
        redirect = 1'b0;
        check_val("t4_v2",   {15'd0, ifid_valid}, 16'd0);
        check_val("t4_rq2",  {15'd0, imem_req},   16'd0);
        step(1);
        check_val("t4_rq3",  {15'd0, imem_req},   16'd0);
        step(1);
        check_val("t4_rq4",  {15'd0, imem_req},   16'd1);
        check_val("t4_addr", imem_addr,           16'h0040);
        check_val("t4_v4",   {15'd0, ifid_valid}, 16'd0);
        step(4);
        check_val("t4_v8",   {15'd0, ifid_valid}, 16'd1);
        check_val("t4_i8",   ifid_instr,    16'h5A5A);
        check_val("t4_pc8",  ifid_pc,       16'h0040);
        check_val("t4_pp8",  ifid_pc_plus2, 16'h0042);

        // HLT then redirect out of halt
        lat = 1;
        do_reset();
        step(8);
        check_val("t5_i",    ifid_instr, 16'hF000);
        check_val("t5_pc",   ifid_pc,    16'h0006);
        check_val("t5_halt", {15'd0, halted}, 16'd1);
        nreq = 0;
        for (int i = 0; i < 100; i++) begin
            if (imem_req) nreq++;
            step(1);
        end
        check_val("t5_noreq", 16'(nreq), 16'd0);
        check_val("t5_halt2", {15'd0, halted}, 16'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        step(1);
        redirect = 1'b0;
        check_val("t5_rreq",  {15'd0, imem_req}, 16'd1);
        check_val("t5_raddr", imem_addr,         16'h0010);
        check_val("t5_unh",   {15'd0, halted},   16'd0);
        step(2);
        check_val("t5_ri",    ifid_instr, 16'h6001);
        check_val("t5_rpc",   ifid_pc,    16'h0010);

        // Asynchronous reset with a response still in flight
        lat = 3;
        do_reset();
        step(4);
        check_val("t6_v4", ifid_instr, 16'h1123);
        step(1);
        rst = 1'b1;
        #1;
        check_val("t6_rv",  {15'd0, ifid_valid}, 16'd0);
        check_val("t6_rrq", {15'd0, imem_req},   16'd0);
        check_val("t6_ri",  ifid_instr,          16'h0000);
        step(2);
        rst = 1'b0;
        #1;
        check_val("t6_req",  {15'd0, imem_req}, 16'd1);
        check_val("t6_addr", imem_addr,         16'h0000);
        step(1);
        check_val("t6_stale", {15'd0, ifid_valid}, 16'd0);
        step(3);
        check_val("t6_v",  {15'd0, ifid_valid}, 16'd1);
        check_val("t6_i",  ifid_instr, 16'h1123);
        check_val("t6_pc", ifid_pc,    16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
